// File: rtl/bsg_link_iddr_pkg.sv
// Shared types for the bsg_link DDR receive aligner: FSM states and the
// word-boundary phase selector.
package bsg_link_iddr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // PHASE_POS: word starts on a posedge; PHASE_NEG: word starts on a negedge.
    typedef enum logic {
        PHASE_POS = 1'b0,
        PHASE_NEG = 1'b1
    } phase_e;

endpackage

// File: rtl/bsg_link_ddr_capture.sv
// Dual-edge input capture: one flop bank on each clock edge, both cleared
// asynchronously.
module bsg_link_ddr_capture #(
    parameter int width_p = 17
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] p_r,
    output logic [width_p-1:0] n_r
);

    logic clk_n;
    assign clk_n = ~clk_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            p_r <= '0;
        end else begin
            p_r <= data_i;
        end
    end

    always_ff @(posedge clk_n or negedge reset_n_i) begin
        if (!reset_n_i) begin
            n_r <= '0;
        end else begin
            n_r <= data_i;
        end
    end

endmodule

// File: rtl/bsg_link_iddr_rx_align.sv
// DDR receive aligner: captures both clock edges, trains on a known token to
// pick the word boundary, and emits registered 2*width_p-bit words.
module bsg_link_iddr_rx_align
    import bsg_link_iddr_pkg::*;
#(
    parameter int                 width_p      = 16,
    parameter logic [width_p-1:0] train_word_p = width_p'(16'h5A3C),
    parameter int                 lock_count_p = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [width_p-1:0]     data_i,
    input  logic                   valid_i,
    input  logic                   train_en_i,
    output logic [2*width_p-1:0]   data_r_o,
    output logic                   valid_o,
    output logic                   locked_o,
    output logic                   swap_o
);

    localparam int                  cnt_w_lp    = $clog2(lock_count_p + 1);
    localparam logic [cnt_w_lp-1:0] lock_cnt_lp = cnt_w_lp'(lock_count_p);

    // Bit width_p of every captured half carries its valid.
    logic [width_p:0] p_r, n_r, n_d_reg;

    bsg_link_ddr_capture #(.width_p(width_p + 1)) capture (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    ({valid_i, data_i}),
        .p_r       (p_r),
        .n_r       (n_r)
    );

    state_e                state_reg, state_next;
    phase_e                phase_reg, phase_next, match_phase;
    logic [cnt_w_lp-1:0]   cnt_reg, cnt_next;
    logic                  swap_reg, swap_next;
    logic                  train_d_reg;
    logic [2*width_p-1:0]  data_reg;
    logic                  valid_reg;

    logic                  norm_match, swap_match;
    logic [2*width_p-1:0]  sel_word;
    logic                  sel_valid;

    assign norm_match  = (p_r[width_p-1:0] == train_word_p) &&
                         (n_r[width_p-1:0] == ~train_word_p);
    assign swap_match  = (n_d_reg[width_p-1:0] == train_word_p) &&
                         (p_r[width_p-1:0] == ~train_word_p);
    assign match_phase = swap_match ? PHASE_NEG : PHASE_POS;

    always_comb begin
        if (swap_reg) begin
            sel_word  = {p_r[width_p-1:0], n_d_reg[width_p-1:0]};
            sel_valid = p_r[width_p] & n_d_reg[width_p];
        end else begin
            sel_word  = {n_r[width_p-1:0], p_r[width_p-1:0]};
            sel_valid = n_r[width_p] & p_r[width_p];
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        phase_next = phase_reg;
        swap_next  = swap_reg;
        unique case (state_reg)
            IDLE: begin
                if (train_en_i) state_next = SEARCH;
            end
            SEARCH: begin
                // Dropping training wins over a lock landing on the same edge.
                if (!train_en_i) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (norm_match || swap_match) begin
                    if (match_phase == phase_reg) begin
                        if (cnt_reg < lock_cnt_lp) cnt_next = cnt_reg + 1'b1;
                    end else begin
                        cnt_next   = cnt_w_lp'(1);
                        phase_next = match_phase;
                    end
                    if (cnt_next == lock_cnt_lp) begin
                        state_next = LOCKED;
                        swap_next  = (phase_next == PHASE_NEG);
                        cnt_next   = '0;
                    end
                end else begin
                    cnt_next = '0;
                end
            end
            LOCKED: begin
                if (train_en_i && !train_d_reg) begin
                    state_next = SEARCH;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            n_d_reg     <= '0;
            train_d_reg <= 1'b0;
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            phase_reg   <= PHASE_POS;
            swap_reg    <= 1'b0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
        end else begin
            n_d_reg     <= n_r;
            train_d_reg <= train_en_i;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            phase_reg   <= phase_next;
            swap_reg    <= swap_next;
            data_reg    <= sel_word;
            valid_reg   <= (state_reg == LOCKED) && !train_en_i && sel_valid;
        end
    end

    assign data_r_o = data_reg;
    assign valid_o  = valid_reg;
    assign locked_o = (state_reg == LOCKED);
    assign swap_o   = swap_reg;

endmodule

// File: tb/tb_bsg_link_iddr_rx_align.sv
// Randomised bench for bsg_link_iddr_rx_align against a half-word stream
// reference model; directed scenarios first, then random training rounds.
module tb_bsg_link_iddr_rx_align;

    localparam logic [15:0] P  = 16'h5A3C;
    localparam logic [15:0] PN = 16'hA5C3;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic [15:0] data     = '0;
    logic        valid    = 1'b0;
    logic        train_en = 1'b0;
    logic [31:0] data_r;
    logic        out_valid, locked, swap;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the last three received halves, oldest first.
    logic [16:0] hist[$];
    logic [31:0] exp_data;
    bit          exp_valid, exp_locked, exp_swap;
    bit          m_search, m_prev_train, m_run_swap;
    int          m_run;

    bsg_link_iddr_rx_align #(
        .width_p      (16),
        .train_word_p (16'h5A3C),
        .lock_count_p (4)
    ) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .data_i     (data),
        .valid_i    (valid),
        .train_en_i (train_en),
        .data_r_o   (data_r),
        .valid_o    (out_valid),
        .locked_o   (locked),
        .swap_o     (swap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        hist = '{17'h0, 17'h0, 17'h0};
        exp_data = '0; exp_valid = 0; exp_locked = 0; exp_swap = 0;
        m_search = 0; m_prev_train = 0; m_run_swap = 0; m_run = 0;
    endtask

    task automatic model_pos(input logic [16:0] cur);
        logic [16:0] first_n, mid_p, last_n;
        bit nm, sm, ph;
        first_n = hist[0]; mid_p = hist[1]; last_n = hist[2];
        nm = (mid_p[15:0] == P) && (last_n[15:0] == PN);
        sm = (first_n[15:0] == P) && (mid_p[15:0] == PN);
        exp_data  = exp_swap ? {mid_p[15:0], first_n[15:0]} : {last_n[15:0], mid_p[15:0]};
        exp_valid = exp_locked && !train_en &&
                    (exp_swap ? (mid_p[16] && first_n[16]) : (last_n[16] && mid_p[16]));
        if (exp_locked) begin
            if (train_en && !m_prev_train) begin
                exp_locked = 0; m_search = 1; m_run = 0;
            end
        end else if (!m_search) begin
            if (train_en) m_search = 1;
        end else if (!train_en) begin
            m_search = 0; m_run = 0;
        end else if (nm || sm) begin
            ph = sm;
            if (m_run == 0 || ph != m_run_swap) begin
                m_run = 1; m_run_swap = ph;
            end else begin
                m_run++;
            end
            if (m_run == 4) begin
                exp_locked = 1; m_search = 0; exp_swap = m_run_swap; m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_prev_train = train_en;
        void'(hist.pop_front());
        hist.push_back(cur);
    endtask

    // Drive one half-word and step across the next clock edge of either kind.
    task automatic half(input logic [15:0] d, input logic v);
        data = d; valid = v;
        @(posedge clk or negedge clk);
        if (!reset_n) model_reset();
        else if (clk) model_pos({v, d});
        else begin
            void'(hist.pop_front());
            hist.push_back({v, d});
        end
        #1;
        if (clk) begin
            check("data_r_o", data_r, exp_data);
            check("valid_o", 32'(out_valid), 32'(exp_valid));
            check("locked_o", 32'(locked), 32'(exp_locked));
            check("swap_o", 32'(swap), 32'(exp_swap));
        end
    endtask

    function automatic logic [15:0] rand_half();
        logic [15:0] r;
        r = 16'($urandom);
        if (r == P || r == PN) r = r ^ 16'h0100;
        return r;
    endfunction

    // Insert one filler half if needed so the next half lands on the wanted edge.
    task automatic pad_to(input bit want_pos);
        if (want_pos != (clk == 1'b0)) half(rand_half(), 1'b0);
    endtask

    task automatic train_words(input bit swapped, input int n);
        pad_to(!swapped);
        for (int i = 0; i < n; i++) begin
            half(P, 1'b1);
            half(PN, 1'b1);
        end
    endtask

    task automatic expect_lock(input string tag, input bit l, input bit s);
        check({tag, "_locked"}, 32'(locked), 32'(l));
        check({tag, "_swap"}, 32'(swap), 32'(s));
    endtask

    initial begin
        model_reset();

        // Reset held with random inputs.
        for (int i = 0; i < 5; i++) begin
            train_en = 1'($urandom);
            half(rand_half(), 1'($urandom));
        end
        reset_n = 1'b1; train_en = 1'b0;
        check("rel_valid", 32'(out_valid), 32'd0);
        check("rel_locked", 32'(locked), 32'd0);
        half(rand_half(), 1'b1);
        half(rand_half(), 1'b1);
        $display("scenario 1 reset: locked=%0d valid=%0d", locked, out_valid);

        // Normal lock then payload.
        train_en = 1'b1;
        half(rand_half(), 1'b0);
        half(rand_half(), 1'b0);
        train_words(1'b0, 4);
        half(rand_half(), 1'b0);
        expect_lock("norm", 1'b1, 1'b0);
        half(rand_half(), 1'b0);
        train_en = 1'b0;
        half(16'h1111, 1'b1);
        half(16'h2222, 1'b1);
        half(rand_half(), 1'b0);
        check("norm_data", data_r, 32'h2222_1111);
        check("norm_valid", 32'(out_valid), 32'd1);
        $display("scenario 2 normal: data=%h valid=%0d", data_r, out_valid);

        // Partial valid.
        half(rand_half(), 1'b0);
        half(16'h3333, 1'b1);
        half(16'h4444, 1'b0);
        half(rand_half(), 1'b1);
        check("part_data", data_r, 32'h4444_3333);
        check("part_valid", 32'(out_valid), 32'd0);
        $display("scenario 5 partial: data=%h valid=%0d", data_r, out_valid);

        // Swapped lock from a normal lock.
        train_en = 1'b1;
        half(rand_half(), 1'b0);
        half(rand_half(), 1'b0);
        check("retrain_locked", 32'(locked), 32'd0);
        train_words(1'b1, 4);
        check("swap_early", 32'(locked), 32'd0);
        half(rand_half(), 1'b0);
        half(rand_half(), 1'b0);
        expect_lock("swap", 1'b1, 1'b1);
        train_en = 1'b0;
        half(16'hBEEF, 1'b1);
        half(16'hCAFE, 1'b1);
        half(rand_half(), 1'b0);
        half(rand_half(), 1'b0);
        check("swap_data", data_r, 32'hCAFE_BEEF);
        check("swap_valid", 32'(out_valid), 32'd1);
        $display("scenario 3 swapped: data=%h valid=%0d", data_r, out_valid);

        // Broken run: 3 good, 1 bad, 4 good.
        train_en = 1'b1;
        half(rand_half(), 1'b0);
        half(rand_half(), 1'b0);
        train_words(1'b0, 3);
        half(P, 1'b1);
        half(16'hA5C2, 1'b1);
        train_words(1'b0, 3);
        half(P, 1'b1);
        check("broken_7", 32'(locked), 32'd0);
        half(PN, 1'b1);
        half(rand_half(), 1'b0);
        expect_lock("broken_8", 1'b1, 1'b0);
        $display("scenario 4 broken run: locked=%0d swap=%0d", locked, swap);

        // Phase flip: 3 swapped words directly followed by normal words.
        train_en = 1'b0;
        half(rand_half(), 1'b1);
        half(rand_half(), 1'b1);
        train_en = 1'b1;
        half(rand_half(), 1'b0);
        half(rand_half(), 1'b0);
        train_words(1'b1, 3);
        train_words(1'b0, 3);
        half(P, 1'b1);
        check("flip_3", 32'(locked), 32'd0);
        half(PN, 1'b1);
        half(rand_half(), 1'b0);
        expect_lock("flip_4", 1'b1, 1'b0);
        $display("scenario 4 phase flip: locked=%0d swap=%0d", locked, swap);

        // Asynchronous reset pulse between edges, then swapped retrain.
        reset_n = 1'b0;
        #1;
        model_reset();
        check("arst_data", data_r, 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        expect_lock("arst", 1'b0, 1'b0);
        #1 reset_n = 1'b1;
        half(rand_half(), 1'b0);
        half(rand_half(), 1'b0);
        train_words(1'b1, 4);
        half(rand_half(), 1'b0);
        half(rand_half(), 1'b0);
        expect_lock("relock", 1'b1, 1'b1);
        train_en = 1'b0;
        for (int i = 0; i < 6; i++) half(rand_half(), 1'b1);
        $display("scenario 6 reset+relock: locked=%0d swap=%0d", locked, swap);

        // Random training rounds and payload.
        for (int r = 0; r < 24; r++) begin
            bit ph;
            int bad;
            ph  = 1'($urandom);
            bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : -1;
            train_en = 1'b0;
            for (int i = 0; i < $urandom_range(2, 6); i++) half(rand_half(), 1'($urandom));
            train_en = 1'b1;
            for (int i = 0; i < $urandom_range(2, 4); i++) half(rand_half(), 1'b0);
            pad_to(!ph);
            for (int w = 0; w < 5; w++) begin
                half(P, 1'b1);
                half((w == bad) ? (PN ^ 16'(1 << $urandom_range(0, 15))) : PN, 1'b1);
            end
            half(rand_half(), 1'b0);
            half(rand_half(), 1'b0);
            train_en = 1'b0;
            for (int i = 0; i < $urandom_range(10, 20); i++) begin
                train_en = ($urandom_range(0, 15) == 0);
                half(rand_half(), ($urandom_range(0, 7) != 0));
            end
            $display("round %0d: phase=%0d bad=%0d locked=%0d swap=%0d", r, ph, bad, locked, swap);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
